// File: rtl/ps_tx_pkg.sv
// Shared definitions for the PCIe PHY TX byte scheduler: FSM state encoding
// and the ordered-set symbols the scheduler can place on the converter input.
package ps_tx_pkg;

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_ARB  = 2'd1,
    S_SEND = 2'd2,
    S_SKP  = 2'd3
  } state_t;

  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] SKP = 8'h1C;

  // Byte idx of a SKP ordered set: one COM followed by three SKP symbols.
  function automatic logic [7:0] skp_os_byte(input logic [1:0] idx);
    return (idx == 2'd0) ? COM : SKP;
  endfunction

endpackage

// File: rtl/ps_rr_arbiter.sv
// Combinational round-robin pick: the search starts one past the last grant
// and wraps modulo NUM_REQ, so the last winner has the lowest priority.
module ps_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic [ID_W-1:0]    next_id,
  output logic               any_req
);

  int idx;

  // Walk the requesters in rotated order and keep the first one found.
  always_comb begin
    next_id = last;
    any_req = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (!any_req && req[idx]) begin
        next_id = ID_W'(idx);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps_tx_scheduler.sv
// TX scheduler sharing one parallel-to-serial converter between NUM_REQ
// byte requesters: link-sync period after reset, then round-robin grants
// with bursts of at most MAX_BURST bytes, one byte per clk_4f cycle.
// Optional build macro PS_TX_SKP_INSERT_EN adds periodic SKP ordered sets
// inserted between bursts.
module ps_tx_scheduler
  import ps_tx_pkg::*;
#(
  parameter int                NUM_REQ    = 4,
  parameter int                DATA_W     = 8,
  parameter int                SYNC_COUNT = 4,
  parameter int                MAX_BURST  = 4,
  parameter logic [DATA_W-1:0] IDLE_SYM   = COM
`ifdef PS_TX_SKP_INSERT_EN
  , parameter int              SKP_INTERVAL = 64
`endif
) (
  input  logic                          clk_4f,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]     req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_W-1:0]             data_out,
  output logic                          valid_out,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          active
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int SYNC_W = (SYNC_COUNT > 2) ? $clog2(SYNC_COUNT) : 1;

  state_t            state;
  state_t            send_exit;
  logic [SYNC_W-1:0] sync_cnt;
  logic [3:0]        burst_cnt;
  logic [ID_W-1:0]   next_id;
  logic              any_req;
  logic              grant_valid;
  logic [DATA_W-1:0] grant_byte;
  logic              burst_done;

  ps_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req     (req_valid),
    .last    (grant_id),
    .next_id (next_id),
    .any_req (any_req)
  );

  // Select the valid bit and byte of the currently granted requester.
  always_comb begin
    grant_valid = 1'b0;
    grant_byte  = IDLE_SYM;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        grant_valid = req_valid[i];
        grant_byte  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Ready depends only on state and grant so requesters never see a loop.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (state == S_SEND) && (grant_id == ID_W'(i));
    end
  end

  assign burst_done = (burst_cnt + 4'd1) == 4'(MAX_BURST);

`ifdef PS_TX_SKP_INSERT_EN
  localparam int SKP_W = (SKP_INTERVAL > 2) ? $clog2(SKP_INTERVAL) : 1;

  logic [SKP_W-1:0] skp_timer;
  logic             skp_pend;
  logic [1:0]       skp_idx;
  logic             skp_done;

  assign skp_done  = (state == S_SKP) && (skp_idx == 2'd3);
  assign send_exit = skp_pend ? S_SKP : S_ARB;

  // Free-running interval timer; a new request wins over a same-cycle clear.
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      skp_timer <= '0;
      skp_pend  <= 1'b0;
    end else begin
      if (skp_done) begin
        skp_pend <= 1'b0;
      end
      if (skp_timer == SKP_W'(SKP_INTERVAL - 1)) begin
        skp_timer <= '0;
        skp_pend  <= 1'b1;
      end else begin
        skp_timer <= skp_timer + 1'b1;
      end
    end
  end
`else
  assign send_exit = S_ARB;
`endif

  // Main scheduler FSM with registered byte/valid toward the converter.
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state     <= S_SYNC;
      data_out  <= IDLE_SYM;
      valid_out <= 1'b0;
      grant_id  <= ID_W'(NUM_REQ - 1);
      active    <= 1'b0;
      sync_cnt  <= '0;
      burst_cnt <= '0;
`ifdef PS_TX_SKP_INSERT_EN
      skp_idx   <= 2'd0;
`endif
    end else begin
      data_out  <= IDLE_SYM;
      valid_out <= 1'b0;
      case (state)
        S_SYNC: begin
          if (sync_cnt == SYNC_W'(SYNC_COUNT - 1)) begin
            state  <= S_ARB;
            active <= 1'b1;
          end else begin
            sync_cnt <= sync_cnt + 1'b1;
          end
        end
        S_ARB: begin
`ifdef PS_TX_SKP_INSERT_EN
          if (skp_pend) begin
            state <= S_SKP;
          end else
`endif
          if (any_req) begin
            grant_id  <= next_id;
            burst_cnt <= '0;
            state     <= S_SEND;
          end
        end
        S_SEND: begin
          if (grant_valid) begin
            data_out  <= grant_byte;
            valid_out <= 1'b1;
            burst_cnt <= burst_cnt + 4'd1;
            if (burst_done) begin
              state <= send_exit;
            end
          end else begin
            state <= send_exit;
          end
        end
`ifdef PS_TX_SKP_INSERT_EN
        S_SKP: begin
          data_out  <= skp_os_byte(skp_idx);
          valid_out <= 1'b1;
          skp_idx   <= skp_idx + 2'd1;
          if (skp_idx == 2'd3) begin
            state <= S_ARB;
          end
        end
`endif
        default: state <= S_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_ps_tx_scheduler.sv
// Self-checking bench for ps_tx_scheduler (default build, no SKP insertion).
// A behavioural model tracks sync progress, the current owner and its byte
// count, and predicts every registered output and the ready vector.
module tb_ps_tx_scheduler;

  localparam int NUM_REQ    = 4;
  localparam int SYNC_COUNT = 4;
  localparam int MAX_BURST  = 4;
  localparam logic [7:0] IDLE = 8'hBC;

  logic        clk_4f = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  data_out;
  logic        valid_out;
  logic [1:0]  grant_id;
  logic        active;

  int num_checks = 0;
  int num_errors = 0;

  // Reference model state
  int         m_sync_left;
  bit         m_active;
  bit         m_owned;
  int         m_owner;
  int         m_taken;
  bit         m_valid;
  logic [7:0] m_data;

  logic [3:0] last_hs;

  ps_tx_scheduler #(
    .NUM_REQ    (NUM_REQ),
    .DATA_W     (8),
    .SYNC_COUNT (SYNC_COUNT),
    .MAX_BURST  (MAX_BURST),
    .IDLE_SYM   (IDLE)
  ) dut (
    .clk_4f    (clk_4f),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .data_out  (data_out),
    .valid_out (valid_out),
    .grant_id  (grant_id),
    .active    (active)
  );

  // Byte clock
  always #5 clk_4f = ~clk_4f;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_sync_left = SYNC_COUNT;
    m_active    = 1'b0;
    m_owned     = 1'b0;
    m_owner     = NUM_REQ - 1;
    m_taken     = 0;
    m_valid     = 1'b0;
    m_data      = IDLE;
  endtask

  // One clock edge of the scheduling rules, given the inputs seen at that edge.
  task automatic modelStep(input logic [3:0] v, input logic [31:0] d);
    bit found;
    m_valid = 1'b0;
    m_data  = IDLE;
    if (!m_active) begin
      m_sync_left--;
      if (m_sync_left == 0) m_active = 1'b1;
    end else if (!m_owned) begin
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
        int idx;
        idx = (m_owner + k) % NUM_REQ;
        if (!found && v[idx]) begin
          found   = 1'b1;
          m_owner = idx;
          m_owned = 1'b1;
          m_taken = 0;
        end
      end
    end else begin
      if (v[m_owner]) begin
        m_valid = 1'b1;
        m_data  = d[8*m_owner +: 8];
        m_taken++;
        if (m_taken == MAX_BURST) m_owned = 1'b0;
      end else begin
        m_owned = 1'b0;
      end
    end
  endtask

  task automatic compareAll();
    logic [3:0] exp_ready;
    exp_ready = m_owned ? (4'b0001 << m_owner) : 4'b0000;
    checkOutput("valid_out", valid_out, m_valid);
    checkOutput("data_out", data_out, m_data);
    checkOutput("req_ready", req_ready, exp_ready);
    checkOutput("grant_id", grant_id, m_owner);
    checkOutput("active", active, m_active);
    if (!active) checkOutput("valid_while_inactive", valid_out, 1'b0);
  endtask

  // Drive one cycle of inputs, let an edge pass, then check everything.
  task automatic applyStimulus(input logic [3:0] v, input logic [31:0] d);
    req_valid = v;
    req_data  = d;
    last_hs   = v & req_ready;
    @(posedge clk_4f);
    modelStep(v, d);
    #1;
    compareAll();
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic doReset();
    reset = 1'b1;
    #1;
    checkOutput("rst_valid", valid_out, 1'b0);
    checkOutput("rst_data", data_out, IDLE);
    checkOutput("rst_ready", req_ready, 4'b0000);
    checkOutput("rst_active", active, 1'b0);
    checkOutput("rst_grant", grant_id, NUM_REQ - 1);
    modelReset();
    @(posedge clk_4f);
    #1;
    compareAll();
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] out_q[$];
    int         gq[$];
    int         hs_per[8];
    logic [7:0] nxt;
    logic [3:0] v;
    logic [3:0] prev_ready;
    int         hs1;

    req_valid = '0;
    req_data  = '0;
    last_hs   = '0;
    reset     = 1'b0;

    // Reset and sync with nothing requesting
    doReset();
    for (int c = 0; c < SYNC_COUNT; c++) begin
      applyStimulus(4'b0000, $urandom);
      if (c == SYNC_COUNT - 2) checkOutput("active_before_4th", active, 1'b0);
    end
    checkOutput("active_after_4th", active, 1'b1);

    // Single requester 2 with bytes 11..16
    nxt = 8'h11;
    for (int c = 0; c < 14; c++) begin
      v = (nxt <= 8'h16) ? 4'b0100 : 4'b0000;
      applyStimulus(v, 32'(nxt) << 16);
      if (last_hs[2]) nxt = nxt + 8'd1;
      if (valid_out) out_q.push_back(data_out);
    end
    checkOutput("single_count", out_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < out_q.size()) checkOutput("single_byte", out_q[i], 8'h11 + i);
    end
    checkOutput("single_grant", grant_id, 2);

    // All requesters valid: grants rotate 0,1,2,3,0 with full bursts
    doReset();
    for (int c = 0; c < SYNC_COUNT; c++) applyStimulus(4'b1111, $urandom);
    for (int i = 0; i < 8; i++) hs_per[i] = 0;
    prev_ready = 4'b0000;
    for (int c = 0; c < 25; c++) begin
      applyStimulus(4'b1111, $urandom);
      if (last_hs != 0 && gq.size() > 0 && gq.size() <= 8) hs_per[gq.size()-1]++;
      if (prev_ready == 0 && req_ready != 0) gq.push_back(int'(grant_id));
      checkOutput("ready_onehot", $onehot0(req_ready), 1'b1);
      prev_ready = req_ready;
    end
    checkOutput("rr_grant_count", gq.size(), 5);
    for (int k = 0; k < 5; k++) begin
      if (k < gq.size()) begin
        checkOutput("rr_order", gq[k], k % NUM_REQ);
        checkOutput("rr_burst_len", hs_per[k], MAX_BURST);
      end
    end

    // Reset in the middle of a burst, then sync repeats with requests pending
    applyStimulus(4'b1111, $urandom);
    applyStimulus(4'b1111, $urandom);
    doReset();
    for (int c = 0; c < SYNC_COUNT; c++) applyStimulus(4'b1111, $urandom);

    // Requester 1 drops after two bytes; requester 2 is granted next
    hs1 = 0;
    for (int c = 0; c < 10 && hs1 < 2; c++) begin
      applyStimulus(4'b0010, $urandom);
      if (last_hs[1]) hs1++;
    end
    checkOutput("drop_hs_count", hs1, 2);
    applyStimulus(4'b0100, $urandom);
    checkOutput("drop_valid", valid_out, 1'b0);
    checkOutput("drop_idle", data_out, IDLE);
    applyStimulus(4'b0100, $urandom);
    checkOutput("drop_next_grant", grant_id, 2);
    checkOutput("drop_next_ready", req_ready, 4'b0100);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 99) == 0) doReset();
      v = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) v = 4'b1111;
      applyStimulus(v, $urandom);
      if (!valid_out) checkOutput("idle_symbol", data_out, IDLE);
    end

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule

// File: doc/ps_tx_scheduler.md
Name: ps_tx_scheduler

Overview:
Transmit-side scheduler that shares one paralelo_serial converter between NUM_REQ byte requesters.
- After reset it sends a link-sync sequence.
- It then grants requesters round-robin with bounded bursts and presents one byte per clk_4f cycle on a registered data/valid pair.
- That pair drives data_in/valid_in of the converter.
- Sits between the lane/FIFO logic and the parallel-to-serial stage in the PCIe PHY TX path.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width; fixed 8 to match the converter
SYNC_COUNT, 4, clk_4f cycles of sync (valid_out=0) after reset before ACTIVE
MAX_BURST, 4, max bytes transferred per grant before rotating (1..15)
IDLE_SYM, 8'hBC, byte on data_out whenever valid_out=0 (COM, K28.5)
SKP_INTERVAL, 64, cycles between SKP insert requests (used only with optional feature)

Ports:
clk_4f  in  1  byte clock, same as converter clk_4f
reset  in  1  asynchronous, active-high
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  NUM_REQ*DATA_W  requester i byte at bits [8i+7:8i]
req_ready  out  NUM_REQ  one-hot or zero; byte taken when req_valid[i]&req_ready[i]
data_out  out  DATA_W  registered byte to converter data_in
valid_out  out  1  registered, to converter valid_in
grant_id  out  clog2(NUM_REQ)  index of current/last grant
active  out  1  high once sync sequence completed

Behaviour:
- Reset (async, immediate, also mid-burst): state=SYNC, data_out=IDLE_SYM, valid_out=0, req_ready=0, grant_id=NUM_REQ-1 (so first search starts at 0), active=0, sync/burst counters=0. An in-flight byte is dropped; requesters must re-present it.
- SYNC: valid_out=0, data_out=IDLE_SYM, req_ready=0 for SYNC_COUNT cycles, then go to ARB; active rises in the same edge and stays 1 until reset.
- ARB: if no req_valid, stay; outputs idle (valid_out=0, IDLE_SYM). Otherwise pick the first i with req_valid[i], searching from grant_id+1 modulo NUM_REQ. Register grant_id=i, burst_cnt=0, go to SEND. req_ready=0 during ARB; one bubble per grant.
- SEND: req_ready[grant_id]=1 (combinational from state and grant only, never from req_valid).
  - On transfer, the next edge gives data_out=req_data byte, valid_out=1 (latency 1 cycle), burst_cnt++.
  - If that transfer makes burst_cnt==MAX_BURST, go to ARB.
  - If req_valid[grant_id]=0 in SEND, there is no transfer: next edge valid_out=0, data_out=IDLE_SYM, go to ARB.
- Rotation: the granted requester has lowest priority in the next ARB. A single always-valid requester gets MAX_BURST bytes, then a bubble, then re-grant.
- Boundary conditions:
  - All requesters valid: order 0,1,2,3,0,… each with MAX_BURST bytes.
  - NUM_REQ wrap handled modulo.
  - valid_out is never 1 while active=0.

Optional Feature:
Macro PS_TX_SKP_INSERT_EN.
- Defined: a free-running counter from reset raises skp_pend every SKP_INTERVAL cycles. When skp_pend is set, ARB (or SEND at burst end / valid drop) enters SKP instead of granting.
  - SKP emits, with valid_out=1 and req_ready=0, the four bytes 8'hBC,8'h1C,8'h1C,8'h1C on consecutive cycles, clears skp_pend, then returns to ARB.
  - A burst is never split.
  - grant_id is unchanged by SKP.
- Undefined: no counter, no SKP state; behaviour exactly as above.

Decomposition:
- Shared package ps_tx_pkg: state encoding (SYNC, ARB, SEND, SKP), symbol constants COM=8'hBC and SKP=8'h1C.
- One sub-module, ps_rr_arbiter: combinational round-robin pick (req vector, last grant -> next index, any_req).

Test Plan:
1. Reset pulse, all req_valid=0, SYNC_COUNT=4 -> valid_out=0 and data_out=8'hBC throughout; active rises on 4th edge after reset release; req_ready stays 0.
2. Only req 2 valid with bytes 8'h11..8'h16 -> one bubble, then 4 bytes 11,12,13,14 with valid_out=1 one cycle after each handshake, bubble, then 15,16; grant_id=2.
3. All 4 valid continuously, MAX_BURST=4 -> grant_id sequence 0,1,2,3,0; each grant exactly 4 handshakes; req_ready one-hot at all times.
4. Req 1 drops valid after 2 bytes -> valid_out=0/data_out=8'hBC next cycle, ARB grants req 2 next.
5. Assert reset mid-burst -> valid_out=0, data_out=8'hBC, req_ready=0 immediately without a clock edge; after release, the SYNC sequence repeats and active=0 until done.
6. With PS_TX_SKP_INSERT_EN, SKP_INTERVAL=64, req 0 always valid -> after the current burst ends, data_out BC,1C,1C,1C with valid_out=1, then req 0 burst resumes; without the macro, no 8'h1C ever appears.
